// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad entry controller.
//   KEY_*        : special key codes from the 4x4 keypad scanner
//   entry_state_t: entry FSM state encoding
//   is_digit()   : true for the ten numeric key codes
package keypad_pkg;

  localparam logic [5:0] KEY_DIGIT_MAX = 6'h09;
  localparam logic [5:0] KEY_STAR      = 6'h0E;  // CLEAR
  localparam logic [5:0] KEY_HASH      = 6'h0F;  // ENTER

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PRESENT = 2'd2
  } entry_state_t;

  function automatic logic is_digit(input logic [5:0] code);
    return code <= KEY_DIGIT_MAX;
  endfunction

endpackage

// File: rtl/keypad_entry_ctrl_if.sv
// Finished-entry handshake between keypad_entry_ctrl and its consumer.
//   entry_data  : packed BCD digits, most recent digit in [3:0]
//   entry_len   : number of digits held
//   entry_valid : entry complete and stable
//   entry_ready : consumer accepts the entry
// master = controller side, slave = consumer side.
interface keypad_entry_ctrl_if #(
  parameter int MAX_DIGITS = 4
);
  logic [4*MAX_DIGITS-1:0] entry_data;
  logic [3:0]              entry_len;
  logic                    entry_valid;
  logic                    entry_ready;

  modport master (output entry_data, output entry_len, output entry_valid, input entry_ready);
  modport slave  (input entry_data, input entry_len, input entry_valid, output entry_ready);
endinterface

// File: rtl/keypad_event_detect.sv
// Turns the keypad scanner's level-type data-enable into one event per press.
//   key_valid/key_code : scanner Data_ena / Dout
//   evt                : high in the cycle key_valid rises (combinational)
//   evt_code           : key code to act on while evt is high
module keypad_event_detect (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] key_code,
  input  logic       key_valid,
  output logic       evt,
  output logic [5:0] evt_code
);

  logic kv_q;

  // kv_q resets to 1 so a key still held when reset is released is not
  // mistaken for a fresh press; the key must be released first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kv_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignment for all clocked state so every register
      // samples pre-edge values regardless of statement order.
      kv_q <= key_valid;
    end
  end

  assign evt      = key_valid & ~kv_q;
  assign evt_code = key_code;

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Assembles keypad presses into BCD entries and presents them over a
// valid/ready handshake.
//   clk, rst_n      : clock, asynchronous active-low reset
//   key_code        : scanner key code
//   key_valid       : scanner data-enable (level, may be held)
//   entry           : finished-entry handshake (master side)
//   busy            : state is not IDLE
//   err_pulse       : overflow digit, empty ENTER, or key pressed while presenting
//   timeout_pulse   : partial entry discarded after inactivity
module keypad_entry_ctrl
  import keypad_pkg::*;
#(
  parameter int MAX_DIGITS     = 4,
  parameter int TIMEOUT_CYCLES = 25_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [5:0]            key_code,
  input  logic                  key_valid,
  keypad_entry_ctrl_if.master   entry,
  output logic                  busy,
  output logic                  err_pulse,
  output logic                  timeout_pulse
);

  localparam int W     = 4 * MAX_DIGITS;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       LEN_MAX  = 4'(MAX_DIGITS);

  logic             evt;
  logic [5:0]       evt_code;
  logic [W-1:0]     digit_ext;

  entry_state_t     state;
  logic [W-1:0]     data_q;
  logic [3:0]       len_q;
  logic             valid_q;
  logic [CNT_W-1:0] idle_cnt;

  keypad_event_detect u_evt (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_code  (key_code),
    .key_valid (key_valid),
    .evt       (evt),
    .evt_code  (evt_code)
  );

  assign digit_ext = W'(evt_code[3:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the digit register is reset too: it drives entry_data directly
      // and must read zero out of reset, not whatever powered up.
      state         <= IDLE;
      data_q        <= '0;
      len_q         <= '0;
      valid_q       <= 1'b0;
      busy          <= 1'b0;
      err_pulse     <= 1'b0;
      timeout_pulse <= 1'b0;
      idle_cnt      <= '0;
    end else begin
      err_pulse     <= 1'b0;
      timeout_pulse <= 1'b0;

      case (state)
        IDLE: begin
          idle_cnt <= '0;
          if (evt && is_digit(evt_code)) begin
            data_q <= digit_ext;
            len_q  <= 4'd1;
            busy   <= 1'b1;
            state  <= COLLECT;
          end else if (evt && evt_code == KEY_HASH) begin
            err_pulse <= 1'b1;  // ENTER with nothing typed
          end
        end

        COLLECT: begin
          if (evt) begin
            // Any key, even an ignored code, counts as activity.
            idle_cnt <= '0;
            if (is_digit(evt_code)) begin
              if (len_q < LEN_MAX) begin
                data_q <= (data_q << 4) | digit_ext;
                len_q  <= len_q + 4'd1;
              end else begin
                err_pulse <= 1'b1;
              end
            end else if (evt_code == KEY_STAR) begin
              data_q <= '0;
              len_q  <= '0;
              busy   <= 1'b0;
              state  <= IDLE;
            end else if (evt_code == KEY_HASH) begin
              valid_q <= 1'b1;
              state   <= PRESENT;
            end
          end else if (idle_cnt == CNT_LAST) begin
            // Expiry is checked only when no key arrives, so a key landing
            // on the expiry cycle wins.
            idle_cnt      <= '0;
            data_q        <= '0;
            len_q         <= '0;
            busy          <= 1'b0;
            timeout_pulse <= 1'b1;
            state         <= IDLE;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end

        PRESENT: begin
          if (valid_q && entry.entry_ready) begin
            data_q  <= '0;
            len_q   <= '0;
            valid_q <= 1'b0;
            busy    <= 1'b0;
            state   <= IDLE;
          end
          // Entry is frozen while presented; a press is always dropped.
          if (evt) begin
            err_pulse <= 1'b1;
          end
        end

        default: begin
          data_q   <= '0;
          len_q    <= '0;
          valid_q  <= 1'b0;
          busy     <= 1'b0;
          idle_cnt <= '0;
          state    <= IDLE;
        end
      endcase
    end
  end

  assign entry.entry_data  = data_q;
  assign entry.entry_len   = len_q;
  assign entry.entry_valid = valid_q;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Self-checking bench for keypad_entry_ctrl (MAX_DIGITS=4, TIMEOUT_CYCLES=8).
module tb_keypad_entry_ctrl;

  localparam int MAXD = 4;
  localparam int TMO  = 8;

  logic       clk;
  logic       rst_n;
  logic [5:0] key_code;
  logic       key_valid;
  logic       busy;
  logic       err_pulse;
  logic       timeout_pulse;

  keypad_entry_ctrl_if #(.MAX_DIGITS(MAXD)) eif ();

  keypad_entry_ctrl #(.MAX_DIGITS(MAXD), .TIMEOUT_CYCLES(TMO)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .key_code      (key_code),
    .key_valid     (key_valid),
    .entry         (eif),
    .busy          (busy),
    .err_pulse     (err_pulse),
    .timeout_pulse (timeout_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  localparam int M_IDLE = 0, M_TYPING = 1, M_SHOWING = 2;
  int          m_mode;
  int unsigned m_digits[$];
  int          m_quiet;     // edges since the last key event
  bit          m_prev_kv;
  bit          m_err, m_tmo;

  task automatic model_reset();
    m_mode = M_IDLE;
    m_digits.delete();
    m_quiet = 0;
    m_prev_kv = 1'b1;
    m_err = 1'b0;
    m_tmo = 1'b0;
  endtask

  function automatic logic [15:0] model_data();
    logic [15:0] v = '0;
    foreach (m_digits[i]) v = {v[11:0], 4'(m_digits[i])};
    return v;
  endfunction

  task automatic model_step(input bit kv, input logic [5:0] code, input bit rdy);
    bit pressed = kv && !m_prev_kv;
    m_prev_kv = kv;
    m_err = 1'b0;
    m_tmo = 1'b0;
    if (m_mode == M_SHOWING) begin
      if (rdy) begin
        m_digits.delete();
        m_mode = M_IDLE;
      end
      if (pressed) m_err = 1'b1;
    end else if (pressed) begin
      m_quiet = 0;
      if (code <= 6'd9) begin
        if (m_digits.size() < MAXD) begin
          m_digits.push_back(int'(code));
          m_mode = M_TYPING;
        end else m_err = 1'b1;
      end else if (code == 6'h0E) begin
        m_digits.delete();
        m_mode = M_IDLE;
      end else if (code == 6'h0F) begin
        if (m_mode == M_IDLE) m_err = 1'b1;
        else m_mode = M_SHOWING;
      end
    end else if (m_mode == M_TYPING) begin
      m_quiet++;
      if (m_quiet == TMO) begin
        m_digits.delete();
        m_mode = M_IDLE;
        m_tmo = 1'b1;
      end
    end
  endtask

  task automatic compare_model();
    check("model.data",  32'(eif.entry_data),  32'(model_data()));
    check("model.len",   32'(eif.entry_len),   32'(m_digits.size()));
    check("model.valid", 32'(eif.entry_valid), 32'(m_mode == M_SHOWING));
    check("model.busy",  32'(busy),            32'(m_mode != M_IDLE));
    check("model.err",   32'(err_pulse),       32'(m_err));
    check("model.tmo",   32'(timeout_pulse),   32'(m_tmo));
  endtask

  // One clock: drive inputs, clock edge, advance model, compare 1 time unit later.
  task automatic step(input bit kv, input logic [5:0] code, input bit rdy);
    key_valid = kv;
    key_code  = code;
    eif.entry_ready = rdy;
    @(posedge clk);
    model_step(kv, code, rdy);
    #1;
    compare_model();
  endtask

  task automatic press(input logic [5:0] code);
    step(1'b1, code, 1'b0);
    step(1'b0, code, 1'b0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        kv;
    logic [5:0]  code;
    logic        rdy;
    logic [15:0] data;
    logic [3:0]  len;
    logic        valid;
    logic        busy;
    logic        err;
  } vec_t;

  vec_t vecs[25];

  int max_len;
  int tmo_seen;

  initial begin
    vecs[0]  = '{1'b1, 6'h01, 1'b0, 16'h0001, 4'd1, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 6'h01, 1'b0, 16'h0001, 4'd1, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 6'h02, 1'b0, 16'h0012, 4'd2, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 6'h02, 1'b0, 16'h0012, 4'd2, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 6'h03, 1'b0, 16'h0123, 4'd3, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 6'h03, 1'b0, 16'h0123, 4'd3, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 6'h0F, 1'b0, 16'h0123, 4'd3, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 6'h0F, 1'b0, 16'h0123, 4'd3, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 6'h00, 1'b0, 16'h0123, 4'd3, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 6'h00, 1'b1, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 6'h00, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 6'h09, 1'b0, 16'h0009, 4'd1, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 6'h09, 1'b0, 16'h0009, 4'd1, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{1'b1, 6'h08, 1'b0, 16'h0098, 4'd2, 1'b0, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 6'h08, 1'b0, 16'h0098, 4'd2, 1'b0, 1'b1, 1'b0};
    vecs[15] = '{1'b1, 6'h07, 1'b0, 16'h0987, 4'd3, 1'b0, 1'b1, 1'b0};
    vecs[16] = '{1'b0, 6'h07, 1'b0, 16'h0987, 4'd3, 1'b0, 1'b1, 1'b0};
    vecs[17] = '{1'b1, 6'h06, 1'b0, 16'h9876, 4'd4, 1'b0, 1'b1, 1'b0};
    vecs[18] = '{1'b0, 6'h06, 1'b0, 16'h9876, 4'd4, 1'b0, 1'b1, 1'b0};
    vecs[19] = '{1'b1, 6'h05, 1'b0, 16'h9876, 4'd4, 1'b0, 1'b1, 1'b1};
    vecs[20] = '{1'b0, 6'h05, 1'b0, 16'h9876, 4'd4, 1'b0, 1'b1, 1'b0};
    vecs[21] = '{1'b1, 6'h0E, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[22] = '{1'b0, 6'h0E, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[23] = '{1'b1, 6'h0F, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b1};
    vecs[24] = '{1'b0, 6'h0F, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0};

    // ---- reset state ----
    rst_n = 1'b0;
    key_valid = 1'b0;
    key_code = '0;
    eif.entry_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst.data",  32'(eif.entry_data),  32'h0);
    check("rst.len",   32'(eif.entry_len),   32'h0);
    check("rst.valid", 32'(eif.entry_valid), 32'h0);
    check("rst.busy",  32'(busy),            32'h0);
    check("rst.err",   32'(err_pulse),       32'h0);
    check("rst.tmo",   32'(timeout_pulse),   32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 6'h00, 1'b0);

    // ---- basic entry, handshake, overflow, clear, empty enter ----
    for (int i = 0; i < 25; i++) begin
      step(vecs[i].kv, vecs[i].code, vecs[i].rdy);
      check($sformatf("vec%0d.data", i),  32'(eif.entry_data),  32'(vecs[i].data));
      check($sformatf("vec%0d.len", i),   32'(eif.entry_len),   32'(vecs[i].len));
      check($sformatf("vec%0d.valid", i), 32'(eif.entry_valid), 32'(vecs[i].valid));
      check($sformatf("vec%0d.busy", i),  32'(busy),            32'(vecs[i].busy));
      check($sformatf("vec%0d.err", i),   32'(err_pulse),       32'(vecs[i].err));
    end

    // ---- timeout: pulse at the 8th edge after the event edge ----
    step(1'b1, 6'h04, 1'b0);
    for (int i = 1; i < TMO; i++) begin
      step(1'b0, 6'h04, 1'b0);
      check("tmo.early", 32'(timeout_pulse), 32'h0);
    end
    step(1'b0, 6'h04, 1'b0);
    check("tmo.pulse", 32'(timeout_pulse), 32'h1);
    check("tmo.data",  32'(eif.entry_data), 32'h0);
    check("tmo.busy",  32'(busy), 32'h0);
    step(1'b0, 6'h04, 1'b0);
    check("tmo.width", 32'(timeout_pulse), 32'h0);

    // ---- key on the expiry edge: key wins, no pulse ----
    step(1'b1, 6'h04, 1'b0);
    for (int i = 1; i < TMO; i++) step(1'b0, 6'h04, 1'b0);
    step(1'b1, 6'h07, 1'b0);
    check("tmo_race.pulse", 32'(timeout_pulse), 32'h0);
    check("tmo_race.data",  32'(eif.entry_data), 32'h0047);
    check("tmo_race.len",   32'(eif.entry_len), 32'd2);
    step(1'b0, 6'h07, 1'b0);
    press(6'h0E);

    // ---- ignored codes: no change, no error, restart the timeout ----
    step(1'b1, 6'h01, 1'b0);
    repeat (5) step(1'b0, 6'h01, 1'b0);
    step(1'b1, 6'h0A, 1'b0);
    check("ign_a.data", 32'(eif.entry_data), 32'h0001);
    check("ign_a.err",  32'(err_pulse), 32'h0);
    repeat (5) step(1'b0, 6'h0A, 1'b0);
    step(1'b1, 6'h20, 1'b0);
    check("ign_20.len", 32'(eif.entry_len), 32'd1);
    check("ign_20.err", 32'(err_pulse), 32'h0);
    for (int i = 1; i < TMO; i++) begin
      step(1'b0, 6'h20, 1'b0);
      check("ign.no_tmo", 32'(timeout_pulse), 32'h0);
    end
    step(1'b0, 6'h20, 1'b0);
    check("ign.tmo", 32'(timeout_pulse), 32'h1);

    // ---- held key: one press, one digit, expires once, no re-trigger ----
    max_len = 0;
    tmo_seen = 0;
    repeat (50) begin
      step(1'b1, 6'h05, 1'b0);
      if (int'(eif.entry_len) > max_len) max_len = int'(eif.entry_len);
      if (timeout_pulse) tmo_seen++;
    end
    check("held.max_len", 32'(max_len), 32'd1);
    check("held.tmo_cnt", 32'(tmo_seen), 32'd1);
    step(1'b0, 6'h05, 1'b0);
    step(1'b1, 6'h06, 1'b0);
    check("held.next", 32'(eif.entry_data), 32'h0006);
    step(1'b0, 6'h06, 1'b0);
    press(6'h0E);

    // ---- reset mid-entry, released while key held ----
    press(6'h01);
    step(1'b1, 6'h02, 1'b0);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_mid.len",  32'(eif.entry_len), 32'h0);
    check("rst_mid.busy", 32'(busy), 32'h0);
    check("rst_mid.data", 32'(eif.entry_data), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      step(1'b1, 6'h03, 1'b0);
      check("rst_held.len", 32'(eif.entry_len), 32'h0);
      check("rst_held.err", 32'(err_pulse), 32'h0);
    end
    step(1'b0, 6'h03, 1'b0);
    step(1'b1, 6'h03, 1'b0);
    check("rst_after.data", 32'(eif.entry_data), 32'h0003);
    step(1'b0, 6'h03, 1'b0);

    // ---- key press together with handshake in PRESENT ----
    press(6'h0F);
    check("sim.valid_pre", 32'(eif.entry_valid), 32'h1);
    step(1'b1, 6'h02, 1'b1);
    check("sim.valid", 32'(eif.entry_valid), 32'h0);
    check("sim.len",   32'(eif.entry_len), 32'h0);
    check("sim.err",   32'(err_pulse), 32'h1);
    check("sim.busy",  32'(busy), 32'h0);
    step(1'b0, 6'h02, 1'b0);

    // ---- randomized traffic against the model ----
    for (int c = 0; c < 3000; c++) begin
      int r;
      logic [5:0] code;
      bit kv, rdy;
      r = int'($urandom_range(0, 99));
      if (r < 60)      code = 6'($urandom_range(0, 9));
      else if (r < 70) code = 6'h0E;
      else if (r < 82) code = 6'h0F;
      else if (r < 90) code = 6'($urandom_range(10, 13));
      else             code = 6'($urandom_range(16, 63));
      // Quiet stretches let partial entries expire now and then.
      if ((c % 200) > 185) kv = 1'b0;
      else kv = ($urandom_range(0, 99) < 40);
      rdy = ($urandom_range(0, 99) < 30);
      step(kv, code, rdy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
